// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR sequencer slice.
// The FIR datapath width and tap count live here so the sequencer and bench agree.
package fir_pkg;

  localparam int SIZE        = 16;
  localparam int STAGE       = 16;
  localparam int FIR_LATENCY = STAGE + 2;

  typedef logic signed [SIZE-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_FIR = 2'd2,
    CAPTURE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/fir_sequencer_fifo.sv
// Small synchronous FIFO holding incoming samples until the FIR is free.
// Head is read combinationally so the pop cycle can load it straight into fir_in.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge ck) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge ck) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fir_sequencer.sv
// Feeds queued samples one at a time to the shared serial-MAC FIR and holds
// each filtered result until the consumer acknowledges it.
module fir_sequencer #(
  parameter int SIZE       = 16,
  parameter int STAGE      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic signed [SIZE-1:0] sample_in,
  input  logic                   sample_valid,
  output logic                   sample_accept,
  output logic signed [SIZE-1:0] fir_in,
  output logic                   fir_input_ready,
  input  logic                   fir_output_ready,
  input  logic signed [SIZE-1:0] fir_out,
  output logic signed [SIZE-1:0] result,
  output logic                   result_valid,
  input  logic                   result_ack,
  output logic [7:0]             overrun_count,
  output logic                   timeout_error,
  output logic                   busy
);

  import fir_pkg::*;

  // Wide enough for the abort threshold even if TIMEOUT is set near the FIR latency.
  localparam int CNT_W = $clog2((TIMEOUT > STAGE + 2) ? TIMEOUT : STAGE + 3) + 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 2);

  seq_state_t              r_state;
  logic signed [SIZE-1:0]  r_fir_in;
  logic                    r_fir_input_ready;
  logic signed [SIZE-1:0]  r_result;
  logic                    r_result_valid;
  logic [7:0]              r_overrun_count;
  logic                    r_timeout_error;
  logic [CNT_W-1:0]        r_wait_cnt;

  logic [SIZE-1:0]         w_head;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;

  assign w_pop = (r_state == IDLE) && !w_empty && (!r_result_valid || result_ack);

  sample_fifo #(
    .WIDTH (SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .ck        (ck),
    .rst       (rst),
    .push      (sample_valid),
    .push_data (sample_in),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge ck) begin
    if (rst) begin
      r_overrun_count <= '0;
    end else if (sample_valid && w_full && (r_overrun_count != 8'hFF)) begin
      r_overrun_count <= r_overrun_count + 8'd1;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      r_state           <= IDLE;
      r_fir_in          <= '0;
      r_fir_input_ready <= 1'b0;
      r_result          <= '0;
      r_result_valid    <= 1'b0;
      r_timeout_error   <= 1'b0;
      r_wait_cnt        <= '0;
    end else begin
      r_fir_input_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_fir_in          <= w_head;
            r_fir_input_ready <= 1'b1;
            r_state           <= ISSUE;
          end
        end
        ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= WAIT_FIR;
        end
        WAIT_FIR: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          // The ISSUE cycle counts toward the budget, so the flag lands TIMEOUT cycles after it.
          if (fir_output_ready) begin
            r_state <= CAPTURE;
          end else if (r_wait_cnt == TO_LAST) begin
            r_timeout_error <= 1'b1;
            r_state         <= IDLE;
          end
        end
        CAPTURE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      // A fresh capture beats a coincident ack of the previous result.
      if (r_state == CAPTURE) begin
        r_result       <= fir_out;
        r_result_valid <= 1'b1;
      end else if (result_ack) begin
        r_result_valid <= 1'b0;
      end
    end
  end

  assign sample_accept   = !w_full;
  assign fir_in          = r_fir_in;
  assign fir_input_ready = r_fir_input_ready;
  assign result          = r_result;
  assign result_valid    = r_result_valid;
  assign overrun_count   = r_overrun_count;
  assign timeout_error   = r_timeout_error;
  assign busy            = (r_state != IDLE);

endmodule
